// File: rtl/mem_bus_arbiter.sv
// Two-requester Avalon-MM arbiter: fetch port (m0) and load/store port (m1) share one bus.
// Define MEM_ARB_RR_EN for round-robin tie-breaking from idle; default is fixed m1-over-m0.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,

    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic                  waitrequest,
    input  logic [DATA_W-1:0]     readdata,

    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;  // 0 = m0, 1 = m1
    logic   req0, req1;
    logic   tie_m0;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef MEM_ARB_RR_EN
    assign tie_m0 = last_owner_q;
`else
    // last_owner is tracked in both builds; only round-robin consults it.
    assign tie_m0 = 1'b0 & last_owner_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = tie_m0 ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!req0) begin
                    state_d = StIdle;
                end else if (!waitrequest) begin
                    // Owner is excluded from the re-arbitration at its completion edge.
                    state_d      = req1 ? StOwn1 : StIdle;
                    last_owner_d = 1'b0;
                end
            end
            StOwn1: begin
                if (!req1) begin
                    state_d = StIdle;
                end else if (!waitrequest) begin
                    state_d      = req0 ? StOwn0 : StIdle;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        address        = '0;
        read           = 1'b0;
        write          = 1'b0;
        writedata      = '0;
        byteenable     = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state_q)
            StOwn0: begin
                address        = m0_address;
                read           = m0_read;
                write          = m0_write;
                writedata      = m0_writedata;
                byteenable     = m0_byteenable;
                m0_waitrequest = waitrequest;
            end
            StOwn1: begin
                address        = m1_address;
                read           = m1_read;
                write          = m1_write;
                writedata      = m1_writedata;
                byteenable     = m1_byteenable;
                m1_waitrequest = waitrequest;
            end
            default: ;
        endcase
    end

    assign m0_readdata = readdata;
    assign m1_readdata = readdata;
    assign grant       = {state_q == StOwn1, state_q == StOwn0};
    assign busy        = |grant;

endmodule
